// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: FSM state encoding, header geometry and the
// helper that puts the 14-byte header into wire order (first byte in bits [7:0]).
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PAD     = 2'd3
  } eth_tx_state_e;

  localparam int ETH_HDR_BYTES       = 14;
  localparam int ETH_MIN_FRAME_BYTES = 60;
  localparam int ETH_MAC_W           = 48;
  localparam int ETH_TYPE_W          = 16;
  localparam int ETH_HDR_W           = ETH_HDR_BYTES * 8;

  // Byte-reverse {dst, src, type} so shifting right by the lane width walks the wire order.
  function automatic logic [ETH_HDR_W-1:0] eth_hdr_wire_order(
    input logic [ETH_MAC_W-1:0]  dst,
    input logic [ETH_MAC_W-1:0]  src,
    input logic [ETH_TYPE_W-1:0] etype
  );
    logic [ETH_HDR_W-1:0] msb_first;
    logic [ETH_HDR_W-1:0] wire_order;
    msb_first  = {dst, src, etype};
    wire_order = '0;
    for (int i = 0; i < ETH_HDR_BYTES; i++) begin
      wire_order[i*8 +: 8] = msb_first[ETH_HDR_W-1-i*8 -: 8];
    end
    return wire_order;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// AXI4-Stream bundle shared by the Ethernet TX blocks (tdata, tkeep, tlast, tuser).
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_hdr_serializer.sv
// Holds the latched 112-bit header and shifts out DATA_WIDTH bits per accepted beat,
// flagging the final header beat.
module eth_hdr_serializer
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ETH_HDR_W-1:0]  hdr_in,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);
  localparam int BEATS = ETH_HDR_W / DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);

  logic [ETH_HDR_W-1:0] shreg_r;
  logic [CNT_W-1:0]     beat_r;

  // header shift register and beat index; both hold while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
      beat_r  <= '0;
    end else if (load) begin
      shreg_r <= hdr_in;
      beat_r  <= '0;
    end else if (advance) begin
      shreg_r <= shreg_r >> DATA_WIDTH;
      beat_r  <= last ? '0 : beat_r + CNT_W'(1);
    end else begin
      shreg_r <= shreg_r;
      beat_r  <= beat_r;
    end
  end

  // current beat and final-beat flag
  always_comb begin
    data = shreg_r[DATA_WIDTH-1:0];
    last = (beat_r == CNT_W'(BEATS - 1));
  end

endmodule

// File: rtl/eth_header_inserter.sv
// Prepends a 14-byte Ethernet header to one payload AXI4-Stream frame (no FCS).
// Optional minimum-frame padding to 60 bytes is built when ETH_HDR_MIN_PAD_EN is defined.
module eth_header_inserter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [ETH_MAC_W-1:0]  hdr_dst_mac,
  input  logic [ETH_MAC_W-1:0]  hdr_src_mac,
  input  logic [ETH_TYPE_W-1:0] hdr_ethertype,
  axi_stream_if.slave           s_axis,
  axi_stream_if.master          m_axis
);
  localparam int KEEP_W = DATA_WIDTH / 8;

  eth_tx_state_e         state_r;
  eth_tx_state_e         next_state_s;
  logic [6:0]            byte_cnt_r;
  logic [7:0]            out_bytes_s;
  logic [7:0]            cnt_sum_s;
  logic                  hdr_fire_s;
  logic                  m_fire_s;
  logic                  ser_advance_s;
  logic                  ser_last_s;
  logic [DATA_WIDTH-1:0] ser_data_s;
  logic [ETH_HDR_W-1:0]  hdr_wire_s;
`ifdef ETH_HDR_MIN_PAD_EN
  logic [7:0]            in_bytes_s;
  logic                  short_frame_s;
  logic                  pad_last_s;
`endif

  assign hdr_wire_s = eth_hdr_wire_order(hdr_dst_mac, hdr_src_mac, hdr_ethertype);

  eth_hdr_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hdr_fire_s),
    .hdr_in  (hdr_wire_s),
    .advance (ser_advance_s),
    .data    (ser_data_s),
    .last    (ser_last_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // handshake strobes and the byte count of the outgoing beat
  always_comb begin
    out_bytes_s = 8'd0;
    for (int i = 0; i < KEEP_W; i++) begin
      out_bytes_s = out_bytes_s + {7'd0, m_axis.tkeep[i]};
    end
    cnt_sum_s  = {1'b0, byte_cnt_r} + out_bytes_s;
    m_fire_s   = m_axis.tvalid && m_axis.tready;
    hdr_fire_s = hdr_valid && hdr_ready;
  end

`ifdef ETH_HDR_MIN_PAD_EN
  // short-frame detection counts the input bytes of the tlast beat before forcing
  always_comb begin
    in_bytes_s = 8'd0;
    for (int i = 0; i < KEEP_W; i++) begin
      in_bytes_s = in_bytes_s + {7'd0, s_axis.tkeep[i]};
    end
    short_frame_s = (({1'b0, byte_cnt_r} + in_bytes_s) < 8'(ETH_MIN_FRAME_BYTES));
    pad_last_s    = (({1'b0, byte_cnt_r} + 8'(KEEP_W)) >= 8'(ETH_MIN_FRAME_BYTES));
  end
`endif

  // saturating frame byte counter, restarted by each accepted header
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_r <= 7'd0;
    end else if (hdr_fire_s) begin
      byte_cnt_r <= 7'd0;
    end else if (m_fire_s) begin
      byte_cnt_r <= (cnt_sum_s > 8'd127) ? 7'd127 : cnt_sum_s[6:0];
    end else begin
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // next-state logic and output steering
  always_comb begin
    next_state_s  = state_r;
    hdr_ready     = 1'b0;
    ser_advance_s = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tlast  = 1'b0;
    m_axis.tuser  = {USER_WIDTH{1'b0}};
    s_axis.tready = 1'b0;
    case (state_r)
      IDLE: begin
        // gated by rst_n so the descriptor port reads not-ready while reset is held
        hdr_ready = rst_n;
        if (hdr_valid && rst_n) begin
          next_state_s = HEADER;
        end else begin
          next_state_s = IDLE;
        end
      end
      HEADER: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = ser_data_s;
        m_axis.tkeep  = '1;
        ser_advance_s = m_axis.tready;
        if (m_axis.tready && ser_last_s) begin
          next_state_s = PAYLOAD;
        end else begin
          next_state_s = HEADER;
        end
      end
      PAYLOAD: begin
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tkeep  = s_axis.tkeep;
        m_axis.tlast  = s_axis.tlast;
        m_axis.tuser  = s_axis.tuser;
        s_axis.tready = m_axis.tready;
`ifdef ETH_HDR_MIN_PAD_EN
        if (s_axis.tvalid && s_axis.tlast && short_frame_s) begin
          // the short frame continues in PAD, so this beat becomes a full, clean one
          m_axis.tlast = 1'b0;
          m_axis.tkeep = '1;
          for (int i = 0; i < KEEP_W; i++) begin
            m_axis.tdata[i*8 +: 8] = s_axis.tkeep[i] ? s_axis.tdata[i*8 +: 8] : 8'h00;
          end
        end else begin
          m_axis.tlast = s_axis.tlast;
        end
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
          next_state_s = short_frame_s ? PAD : IDLE;
        end else begin
          next_state_s = PAYLOAD;
        end
`else
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = PAYLOAD;
        end
`endif
      end
`ifdef ETH_HDR_MIN_PAD_EN
      PAD: begin
        m_axis.tvalid = 1'b1;
        m_axis.tkeep  = '1;
        m_axis.tlast  = pad_last_s;
        if (m_axis.tready && pad_last_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = PAD;
        end
      end
`endif
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule
